mc_datapath: RTL
================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, register/ALU/data width; legal values 32 or 64.
REQ-002 SHALL have parameter REGCOUNT, default 32, architectural registers; legal values 16 or 32.
REQ-003 SHALL have parameter INITIAL_PC, default 32'h00400000, PC value loaded on reset.
REQ-004 SHALL have ports as follows; reset rst, synchronous, active-high; clock clk:
  clk  input  1  clock, all state updates on rising edge
  rst  input  1  synchronous active-high reset
  imem_req  output  1  instruction fetch request
  imem_addr  output  32  fetch address (equals pc)
  imem_rdata  input  32  instruction word
  imem_ready  input  1  fetch complete, imem_rdata valid this cycle
  dmem_req  output  1  data access request
  dmem_we  output  1  1 = store, 0 = load
  dmem_addr  output  DATAWIDTH  data byte address
  dmem_wdata  output  DATAWIDTH  store data
  dmem_rdata  input  DATAWIDTH  load data
  dmem_ready  input  1  data access complete
  pc  output  32  current program counter
  state  output  3  FSM state encoding
  retire  output  1  one-cycle pulse per completed instruction
  halted  output  1  sticky illegal-instruction indication
  instret  output  32  retired-instruction count

Function
REQ-005 SHALL execute RV32I subset: ADD SUB AND OR XOR SLT SLL SRL, ADDI ANDI ORI XORI SLTI, LW, SW, BEQ, BNE; every other encoding is illegal.
REQ-006 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; state output SHALL equal current encoding.
REQ-007 FETCH: imem_req=1, imem_addr=pc; stay until imem_ready=1, then latch imem_rdata into IR, go DECODE.
REQ-008 DECODE: read rs1/rs2 into operand registers, sign-extend I/S/B immediates to DATAWIDTH; illegal opcode/funct or any register index >= REGCOUNT -> HALT; else EXEC.
REQ-009 EXEC: ALU/R/I -> WB; LW/SW -> MEM with address rs1+imm; BEQ/BNE -> pc <= taken ? pc+B-imm : pc+4, retire, -> FETCH.
REQ-010 MEM: dmem_req=1, dmem_addr, dmem_we, dmem_wdata held stable until dmem_ready=1; SW then pc<=pc+4, retire, -> FETCH; LW latches dmem_rdata, -> WB.
REQ-011 WB: write result to rd unless rd=0, pc<=pc+4, retire, -> FETCH.
REQ-012 Zero-wait latency: branch 3, R/I/SW 4, LW 5 cycles; each wait cycle on ready adds exactly one cycle.
REQ-013 Register x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-014 SLT/SLTI signed compare; SLL/SRL use low log2(DATAWIDTH) bits of shift operand; all arithmetic wraps modulo 2^DATAWIDTH.
REQ-015 PC arithmetic SHALL wrap modulo 2^32; imem ready or dmem ready while corresponding req=0 SHALL be ignored.
REQ-016 HALT: halted=1, no req asserted, no writes, no retire; exit only by rst.

Reset
REQ-017 On rst=1 at a clock edge: pc=INITIAL_PC, state=FETCH, halted=0, instret=0, IR=0; registers other than x0 not reset.
REQ-018 During and the cycle after reset: imem_req=0 only while rst=1; dmem_req=0, retire=0; reset mid-transaction aborts it with no register write or PC update.

Configuration
REQ-019 Macro MC_DATAPATH_INSTRET_EN defined: instret increments by 1 on each retire pulse, wrapping at 2^32; undefined: counter not built, instret tied to 0.

Verification
REQ-020 Reset, imem_ready=1 always: first imem_addr=32'h00400000; ADDI x1,x0,5 -> x1=5, retire after 4 cycles, pc=32'h00400004.
REQ-021 ADDI x1,x0,-1; SLT x2,x1,x0 -> x2=1; ADD x0,x1,x1 -> x0 still reads 0.
REQ-022 LW x3,8(x0) with dmem_ready delayed 3 cycles, dmem_rdata=32'hDEADBEEF -> dmem_addr=8 stable throughout, x3=32'hDEADBEEF, 8 cycles total.
REQ-023 BEQ x0,x0,-8 at pc 32'h00400010 -> next imem_addr=32'h00400008, 3 cycles; BNE x0,x0 -> pc+4.
REQ-024 Word 32'hFFFFFFFF fetched -> state=HALT, halted=1, no further requests; rst -> pc=INITIAL_PC, halted=0.
REQ-025 With MC_DATAPATH_INSTRET_EN, 10 retired instructions -> instret=10; without it instret=0.

Source files
------------

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
// Define MC_DATAPATH_INSTRET_EN to build the retired-instruction counter; otherwise instret reads 0.
module mc_datapath #(
   parameter int          DATAWIDTH  = 32,
   parameter int          REGCOUNT   = 32,
   parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic [31:0]          imem_rdata,
   input  logic                 imem_ready,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DATAWIDTH-1:0] dmem_addr,
   output logic [DATAWIDTH-1:0] dmem_wdata,
   input  logic [DATAWIDTH-1:0] dmem_rdata,
   input  logic                 dmem_ready,
   output logic [31:0]          pc,
   output logic [2:0]           state,
   output logic                 retire,
   output logic                 halted,
   output logic [31:0]          instret
);

   // state  | meaning
   // FETCH  | request IR from imem at pc, wait for imem_ready
   // DECODE | read operands, build immediate, trap illegal encodings
   // EXEC   | ALU / address generation; branches resolve and retire here
   // MEM    | hold data request until dmem_ready; stores retire here
   // WB     | write rd, advance pc, retire
   // HALT   | illegal instruction seen; only rst leaves
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_t;

   localparam int          SHW     = $clog2(DATAWIDTH);
   localparam int          RIW     = $clog2(REGCOUNT);
   localparam logic [5:0]  REG_LIM = 6'(REGCOUNT);

   state_t               r_state, w_next;
   logic [31:0]          r_pc;
   logic [31:0]          r_ir;
   logic [DATAWIDTH-1:0] r_op_a, r_op_b, r_imm, r_result;
   logic [DATAWIDTH-1:0] r_regs [REGCOUNT];

   logic [6:0]           w_opcode, w_funct7;
   logic [4:0]           w_rd, w_rs1, w_rs2;
   logic [2:0]           w_funct3;
   logic                 w_is_alu_r, w_is_alu_i, w_is_lw, w_is_sw, w_is_br;
   logic                 w_legal, w_regs_ok, w_taken;
   alu_op_t              w_alu_op;
   logic [DATAWIDTH-1:0] w_rs1_val, w_rs2_val, w_imm, w_alu_b, w_alu_y;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_funct3 = r_ir[14:12];
   assign w_rs1    = r_ir[19:15];
   assign w_rs2    = r_ir[24:20];
   assign w_funct7 = r_ir[31:25];

   always_comb begin
      w_is_alu_r = 1'b0;
      w_is_alu_i = 1'b0;
      w_is_lw    = 1'b0;
      w_is_sw    = 1'b0;
      w_is_br    = 1'b0;
      w_alu_op   = ALU_ADD;
      case (w_opcode)
         7'b0110011: begin
            if (w_funct7 == 7'b0000000) begin
               w_is_alu_r = 1'b1;
               case (w_funct3)
                  3'b000:  w_alu_op = ALU_ADD;
                  3'b001:  w_alu_op = ALU_SLL;
                  3'b010:  w_alu_op = ALU_SLT;
                  3'b100:  w_alu_op = ALU_XOR;
                  3'b101:  w_alu_op = ALU_SRL;
                  3'b110:  w_alu_op = ALU_OR;
                  3'b111:  w_alu_op = ALU_AND;
                  default: w_is_alu_r = 1'b0;
               endcase
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
               w_is_alu_r = 1'b1;
               w_alu_op   = ALU_SUB;
            end
         end
         7'b0010011: begin
            w_is_alu_i = 1'b1;
            case (w_funct3)
               3'b000:  w_alu_op = ALU_ADD;
               3'b010:  w_alu_op = ALU_SLT;
               3'b100:  w_alu_op = ALU_XOR;
               3'b110:  w_alu_op = ALU_OR;
               3'b111:  w_alu_op = ALU_AND;
               default: w_is_alu_i = 1'b0;
            endcase
         end
         7'b0000011: w_is_lw = (w_funct3 == 3'b010);
         7'b0100011: w_is_sw = (w_funct3 == 3'b010);
         7'b1100011: w_is_br = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
         default: ;
      endcase
   end

   assign w_legal   = w_is_alu_r | w_is_alu_i | w_is_lw | w_is_sw | w_is_br;
   // Only register fields the format actually uses are range-checked.
   assign w_regs_ok = ({1'b0, w_rs1} < REG_LIM)
                    && (!(w_is_alu_r | w_is_sw | w_is_br) || ({1'b0, w_rs2} < REG_LIM))
                    && (!(w_is_alu_r | w_is_alu_i | w_is_lw) || ({1'b0, w_rd} < REG_LIM));

   assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1[RIW-1:0]];
   assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2[RIW-1:0]];

   always_comb begin
      w_imm = {{(DATAWIDTH-12){r_ir[31]}}, r_ir[31:20]};
      if (w_is_sw)
         w_imm = {{(DATAWIDTH-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      else if (w_is_br)
         w_imm = {{(DATAWIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
   end

   assign w_alu_b = w_is_alu_r ? r_op_b : r_imm;

   always_comb begin
      w_alu_y = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_y = r_op_a + w_alu_b;
         ALU_SUB: w_alu_y = r_op_a - w_alu_b;
         ALU_AND: w_alu_y = r_op_a & w_alu_b;
         ALU_OR:  w_alu_y = r_op_a | w_alu_b;
         ALU_XOR: w_alu_y = r_op_a ^ w_alu_b;
         ALU_SLT: w_alu_y = {{(DATAWIDTH-1){1'b0}}, ($signed(r_op_a) < $signed(w_alu_b))};
         ALU_SLL: w_alu_y = r_op_a << w_alu_b[SHW-1:0];
         ALU_SRL: w_alu_y = r_op_a >> w_alu_b[SHW-1:0];
         default: w_alu_y = '0;
      endcase
   end

   assign w_taken = w_funct3[0] ? (r_op_a != r_op_b) : (r_op_a == r_op_b);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (imem_ready) w_next = S_DECODE;
         S_DECODE: w_next = (w_legal && w_regs_ok) ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (w_is_br)                w_next = S_FETCH;
            else if (w_is_lw | w_is_sw) w_next = S_MEM;
            else                        w_next = S_WB;
         end
         S_MEM:    if (dmem_ready) w_next = w_is_sw ? S_FETCH : S_WB;
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= INITIAL_PC;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_FETCH: if (imem_ready) r_ir <= imem_rdata;
            S_EXEC:  if (w_is_br) r_pc <= w_taken ? (r_pc + r_imm[31:0]) : (r_pc + 32'd4);
            S_MEM:   if (dmem_ready && w_is_sw) r_pc <= r_pc + 32'd4;
            S_WB:    r_pc <= r_pc + 32'd4;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (r_state)
         S_DECODE: begin
            r_op_a <= w_rs1_val;
            r_op_b <= w_rs2_val;
            r_imm  <= w_imm;
         end
         S_EXEC:  r_result <= w_alu_y;
         S_MEM:   if (dmem_ready && w_is_lw) r_result <= dmem_rdata;
         default: ;
      endcase
      if (!rst && r_state == S_WB && w_rd != 5'd0)
         r_regs[w_rd[RIW-1:0]] <= r_result;
   end

   assign imem_req   = (r_state == S_FETCH) && !rst;
   assign imem_addr  = r_pc;
   assign dmem_req   = (r_state == S_MEM) && !rst;
   assign dmem_we    = w_is_sw;
   assign dmem_addr  = r_result;
   assign dmem_wdata = r_op_b;
   assign pc         = r_pc;
   assign state      = r_state;
   assign halted     = (r_state == S_HALT);
   assign retire     = !rst && (((r_state == S_EXEC) && w_is_br)
                             || ((r_state == S_MEM) && w_is_sw && dmem_ready)
                             || (r_state == S_WB));

`ifdef MC_DATAPATH_INSTRET_EN
   logic [31:0] r_instret;

   always_ff @(posedge clk) begin
      if (rst)         r_instret <= '0;
      else if (retire) r_instret <= r_instret + 32'd1;
   end

   assign instret = r_instret;
`else
   assign instret = '0;
`endif

endmodule
